// File: rtl/scd_bus_pkg.sv
// Shared constants for the CPU bus responder: bus widths, I/O register offsets
// and STATUS bit positions.
package scd_bus_pkg;

   localparam int unsigned BUS_DATA_W = 16;
   localparam int unsigned BUS_ADDR_W = 8;
   localparam int unsigned IO_OFF_W   = 4;

   // Byte offsets of the I/O registers inside the 16-byte page
   localparam logic [IO_OFF_W-1:0] IO_CYCLE  = 4'h0;
   localparam logic [IO_OFF_W-1:0] IO_TX     = 4'h2;
   localparam logic [IO_OFF_W-1:0] IO_STATUS = 4'h4;
   localparam logic [IO_OFF_W-1:0] IO_HALT   = 4'h6;

   localparam int unsigned ST_EMPTY = 0;
   localparam int unsigned ST_FULL  = 1;
   localparam int unsigned ST_OVF   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data-only and deliberately not reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bus_responder.sv
// CPU bus target: word RAM plus an I/O page with a cycle counter, a console
// TX FIFO drained over valid/ready, and a sticky halt flag.
module bus_responder
   import scd_bus_pkg::*;
#(
   parameter int unsigned            FIFO_DEPTH = 4,
   parameter logic [BUS_ADDR_W-1:0]  IO_BASE    = 8'hF0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [BUS_ADDR_W-1:0] addr,
   input  logic [BUS_DATA_W-1:0] wdata,
   output logic [BUS_DATA_W-1:0] rdata,
   output logic                  out_valid,
   output logic [BUS_DATA_W-1:0] out_data,
   input  logic                  out_ready,
   output logic                  halt
);

   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RAM_WORDS = 2 ** (BUS_ADDR_W - 1);

   // Full word space is allocated; words shadowed by the I/O page are never used
   logic [BUS_DATA_W-1:0] ram [RAM_WORDS];

   logic                  io_hit;
   logic [IO_OFF_W-1:0]   io_off;
   logic [BUS_ADDR_W-2:0] word_idx;
   logic                  unused_addr_lsb;

   logic wr_cycle;
   logic wr_tx;
   logic wr_status;
   logic wr_halt;

   logic [BUS_DATA_W-1:0] cycle_cnt;
   logic                  ovf;
   logic [BUS_DATA_W-1:0] status_word;

   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

   assign io_hit          = (addr[BUS_ADDR_W-1:4] == IO_BASE[BUS_ADDR_W-1:4]);
   assign io_off          = {addr[3:1], 1'b0};
   assign word_idx        = addr[BUS_ADDR_W-1:1];
   assign unused_addr_lsb = addr[0];

   assign wr_cycle  = we & io_hit & (io_off == IO_CYCLE);
   assign wr_tx     = we & io_hit & (io_off == IO_TX);
   assign wr_status = we & io_hit & (io_off == IO_STATUS);
   assign wr_halt   = we & io_hit & (io_off == IO_HALT);

   assign out_valid = ~fifo_empty;
   assign fifo_pop  = out_valid & out_ready;

   sync_fifo #(
      .WIDTH (BUS_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_tx),
      .pop   (fifo_pop),
      .wdata (wdata),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (we & ~io_hit) ram[word_idx] <= wdata;
   end

   // Counter write wins over increment; ovf set and W1C clear never coincide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         ovf       <= 1'b0;
         halt      <= 1'b0;
      end else begin
         cycle_cnt <= wr_cycle ? wdata : cycle_cnt + BUS_DATA_W'(1);
         if (wr_tx & fifo_full & ~fifo_pop)
            ovf <= 1'b1;
         else if (wr_status & wdata[ST_OVF])
            ovf <= 1'b0;
         if (wr_halt) halt <= 1'b1;
      end
   end

   always_comb begin
      status_word                   = '0;
      status_word[BUS_DATA_W-1:8]   = 8'(fifo_count);
      status_word[ST_OVF]           = ovf;
      status_word[ST_FULL]          = fifo_full;
      status_word[ST_EMPTY]         = fifo_empty;
   end

   // Zero-latency read path; shows pre-write state during a write cycle
   always_comb begin
      rdata = '0;
      if (io_hit) begin
         case (io_off)
            IO_CYCLE:  rdata = cycle_cnt;
            IO_STATUS: rdata = status_word;
            IO_HALT:   rdata = BUS_DATA_W'(halt);
            default:   rdata = '0;
         endcase
      end else begin
         rdata = ram[word_idx];
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a queue/array model tracks expected bus
// state and is compared every negedge, plus literal checks of key scenarios.
module tb_bus_responder;

   localparam int unsigned DEPTH = 4;

   logic        clk       = 1'b0;
   logic        rst       = 1'b0;
   logic        we        = 1'b0;
   logic [7:0]  addr      = 8'h00;
   logic [15:0] wdata     = 16'h0000;
   logic        out_ready = 1'b0;
   logic [15:0] rdata;
   logic        out_valid;
   logic [15:0] out_data;
   logic        halt;

   bus_responder #(
      .FIFO_DEPTH (DEPTH),
      .IO_BASE    (8'hF0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .halt      (halt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   // Behavioural model of the bus-visible state
   logic [15:0] ram_m [128];
   bit          known [128];
   logic [15:0] q_m [$];
   logic [15:0] cyc_m = 16'h0000;
   bit          ovf_m = 1'b0;
   bit          halt_m = 1'b0;
   logic [15:0] drained [$];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_rd(input logic [7:0] a, output logic [15:0] v);
      int sz;
      sz = q_m.size();
      v  = 16'h0000;
      if (a[7:4] == 4'hF) begin
         case (a[3:1])
            3'd0:    v = cyc_m;
            3'd2:    v = {8'(sz), 5'b0, ovf_m, sz == int'(DEPTH), sz == 0};
            3'd3:    v = {15'b0, halt_m};
            default: v = 16'h0000;
         endcase
         return 1'b1;
      end
      if (known[a[7:1]]) begin
         v = ram_m[a[7:1]];
         return 1'b1;
      end
      return 1'b0;
   endfunction

   initial begin
      for (int i = 0; i < 128; i++) known[i] = 1'b0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            cyc_m  = 16'h0000;
            q_m.delete();
            ovf_m  = 1'b0;
            halt_m = 1'b0;
         end else begin
            bit io;
            io = (addr[7:4] == 4'hF);
            if (out_ready && q_m.size() > 0) void'(q_m.pop_front());
            cyc_m = (we && io && addr[3:1] == 3'd0) ? wdata : cyc_m + 16'd1;
            if (we && io && addr[3:1] == 3'd1) begin
               if (q_m.size() < int'(DEPTH)) q_m.push_back(wdata);
               else ovf_m = 1'b1;
            end
            if (we && io && addr[3:1] == 3'd2 && wdata[2]) ovf_m = 1'b0;
            if (we && io && addr[3:1] == 3'd3) halt_m = 1'b1;
            if (we && !io) begin
               ram_m[addr[7:1]] = wdata;
               known[addr[7:1]] = 1'b1;
            end
         end
      end
   end

   task automatic monitor();
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("out_valid", 16'(out_valid), 16'(q_m.size() > 0));
            if (q_m.size() > 0) check("out_data", out_data, q_m[0]);
            check("halt", 16'(halt), 16'(halt_m));
            if (exp_rd(addr, e)) check("rdata", rdata, e);
            if (out_valid && out_ready) drained.push_back(out_data);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      we = 1'b1; addr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic rd_expect(input string nm, input logic [7:0] a, input logic [15:0] exp);
      we = 1'b0; addr = a;
      @(negedge clk);
      check(nm, rdata, exp);
      step();
   endtask

   task automatic check_drain(input string nm, input int base, input logic [15:0] exp [$]);
      check({nm, "_count"}, 16'(drained.size() - base), 16'(exp.size()));
      for (int k = 0; k < exp.size(); k++) begin
         if (drained.size() > base + k) check($sformatf("%s_%0d", nm, k), drained[base+k], exp[k]);
      end
   endtask

   initial begin
      int          base;
      logic [15:0] v;
      fork
         monitor();
      join_none

      #2 rst = 1'b1;
      mon_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      rd_expect("por_cycle", 8'hF0, 16'h0000);
      rd_expect("por_status", 8'hF4, 16'h0001);

      // RAM write/read, odd address alias, read-during-write returns old value
      wr(8'h10, 16'hBEEF);
      rd_expect("ram_10", 8'h10, 16'hBEEF);
      rd_expect("ram_11", 8'h11, 16'hBEEF);
      we = 1'b1; addr = 8'h10; wdata = 16'h5555;
      @(negedge clk);
      check("ram_rd_old", rdata, 16'hBEEF);
      step();
      we = 1'b0;
      rd_expect("ram_10_new", 8'h10, 16'h5555);
      wr(8'hEE, 16'h1234);
      rd_expect("ram_EE", 8'hEE, 16'h1234);

      // Counter load and wrap
      wr(8'hF0, 16'hFFFE);
      rd_expect("cyc_load", 8'hF0, 16'hFFFE);
      rd_expect("cyc_ffff", 8'hF0, 16'hFFFF);
      rd_expect("cyc_wrap", 8'hF0, 16'h0000);

      // FIFO overflow, reserved space, drain, W1C
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(8'hF2, 16'(17 * (i + 1)));
      rd_expect("st_full_ovf", 8'hF4, 16'h0406);
      rd_expect("tx_read", 8'hF2, 16'h0000);
      rd_expect("rsv_F8", 8'hF8, 16'h0000);
      wr(8'hFA, 16'hFFFF);
      rd_expect("rsv_FA", 8'hFA, 16'h0000);
      base = drained.size();
      addr = 8'h00;
      out_ready = 1'b1;
      repeat (6) step();
      out_ready = 1'b0;
      check_drain("drain4", base, '{16'h0011, 16'h0022, 16'h0033, 16'h0044});
      rd_expect("st_empty_ovf", 8'hF4, 16'h0005);
      wr(8'hF4, 16'h0004);
      rd_expect("st_w1c", 8'hF4, 16'h0001);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) wr(8'hF2, 16'h00A1 + 16'(i));
      rd_expect("st_full", 8'hF4, 16'h0402);
      base = drained.size();
      we = 1'b1; addr = 8'hF2; wdata = 16'h00AA; out_ready = 1'b1;
      step();
      we = 1'b0; out_ready = 1'b0;
      rd_expect("st_pushpop", 8'hF4, 16'h0402);
      addr = 8'h00;
      out_ready = 1'b1;
      repeat (7) step();
      out_ready = 1'b0;
      check_drain("pushpop", base,
                  '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00AA});
      rd_expect("st_drained", 8'hF4, 16'h0001);

      // Program-style: fetch "hi" from preloaded RAM, print it, then halt
      dut.ram[32] = 16'h0068; ram_m[32] = 16'h0068; known[32] = 1'b1;
      dut.ram[33] = 16'h0069; ram_m[33] = 16'h0069; known[33] = 1'b1;
      out_ready = 1'b1;
      base = drained.size();
      for (int i = 0; i < 2; i++) begin
         we = 1'b0; addr = 8'h40 + 8'(2 * i);
         @(negedge clk);
         v = rdata;
         step();
         wr(8'hF2, v);
      end
      wr(8'hF6, 16'h0001);
      addr = 8'h00;
      repeat (3) step();
      check_drain("print", base, '{16'h0068, 16'h0069});
      @(negedge clk);
      check("halt_set", 16'(halt), 16'h0001);
      step();
      rd_expect("halt_reg", 8'hF6, 16'h0001);

      // Asynchronous reset mid-cycle with words queued
      out_ready = 1'b0;
      wr(8'hF2, 16'h0001);
      wr(8'hF2, 16'h0002);
      wr(8'hF2, 16'h0003);
      addr = 8'hF4;
      @(negedge clk);
      check("pre_rst_valid", 16'(out_valid), 16'h0001);
      check("pre_rst_status", rdata, 16'h0300);
      step();
      #2 rst = 1'b1;
      #1;
      check("rst_valid", 16'(out_valid), 16'h0000);
      check("rst_halt", 16'(halt), 16'h0000);
      check("rst_status", rdata, 16'h0001);
      step();
      rst = 1'b0;
      rd_expect("rst_cycle0", 8'hF0, 16'h0000);
      rd_expect("rst_cycle1", 8'hF0, 16'h0001);
      rd_expect("ram_kept", 8'h10, 16'h5555);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
